// File: rtl/source_pkg.sv
// source_pkg: FSM states, mode codes and config_reg
// field map shared by the source stream blocks.
package source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    MODE_LINEAR = 2'b00,
    MODE_OFFSET = 2'b01,
    MODE_CONT   = 2'b10,
    MODE_CIRC   = 2'b11
  } mode_t;

  localparam int CFG_DEPTH_LSB  = 0;
  localparam int CFG_DEPTH_W    = 16;
  localparam int CFG_OFFSET_LSB = 16;
  localparam int CFG_OFFSET_W   = 16;
  localparam int CFG_MODE_LSB   = 32;
  localparam int CFG_MODE_W     = 2;
  localparam int CFG_WRAP_LSB   = 48;
  localparam int CFG_WRAP_W     = 16;
  localparam int CFG_STRIDE_LSB = 64;
  localparam int CFG_STRIDE_W   = 8;

  typedef struct packed {
    logic [CFG_DEPTH_W-1:0]  depth;
    logic [CFG_OFFSET_W-1:0] offset;
    mode_t                   mode;
    logic [CFG_WRAP_W-1:0]   wrap;
    logic [CFG_STRIDE_W-1:0] stride;
  } cfg_t;

  function automatic cfg_t unpack_cfg(
    input logic [127:0] r
  );
    cfg_t c;
    c.depth  = r[CFG_DEPTH_LSB +: CFG_DEPTH_W];
    c.offset = r[CFG_OFFSET_LSB +: CFG_OFFSET_W];
    c.mode   = mode_t'(r[CFG_MODE_LSB +: CFG_MODE_W]);
    c.wrap   = r[CFG_WRAP_LSB +: CFG_WRAP_W];
    c.stride = r[CFG_STRIDE_LSB +: CFG_STRIDE_W];
    return c;
  endfunction

endpackage

// File: rtl/source_delay_line.sv
// source_delay_line: DEPTH-cycle valid pipeline.
// clk/rst: clock, sync reset; valid: in; delayed: out
// DEPTH cycles later; pending: any bit in flight.
module source_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  output logic delayed,
  output logic pending
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign delayed = valid;
      assign pending = 1'b0;
    end else begin : g_pipe
      logic [DEPTH-1:0] pipe;

      always_ff @(posedge clk) begin
        if (rst) begin
          pipe <= '0;
        end else begin
          pipe[0] <= valid;
          for (int i = 1; i < DEPTH; i++)
            pipe[i] <= pipe[i-1];
        end
      end

      assign delayed = pipe[DEPTH-1];
      assign pending = |pipe;
    end
  endgenerate

endmodule

// File: rtl/source_stream.sv
// source_stream: streams memory words into a FIFO.
// Ports: start_i/abort_i/afull_i control, config_reg
// latched on start; re_mem_o/addr_mem_o drive memory;
// we_fifo_o/data_o write FIFO; status_reg reports
// {0000, aborted, stall, busy, done}.
module source_stream
  import source_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int READ_LAT   = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  afull_i,
  input  logic [127:0]          config_reg,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  re_mem_o,
  output logic [ADDR_WIDTH-1:0] addr_mem_o,
  output logic                  we_fifo_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [7:0]            status_reg
);

  // pos must hold wrap_len (up to 2^16) or 2^ADDR_WIDTH
  localparam int PW =
    (ADDR_WIDTH > 16 ? ADDR_WIDTH : 16) + 1;

  state_t                state_q, state_d;
  mode_t                 mode_q;
  logic [CNT_WIDTH-1:0]  depth_q, issued_q;
  logic [ADDR_WIDTH-1:0] offset_q, addr_q, cont_q;
  logic [7:0]            stride_q;
  logic [PW-1:0]         wrap_q, pos_q;
  logic                  aborted_q;

  cfg_t                  cfg;
  logic                  cfg_unused;
  logic                  accept, remain, issue;
  logic                  inflight, stall;
  logic [ADDR_WIDTH-1:0] off_in, start_addr, addr_step;
  logic [PW-1:0]         pos_sum, pos_nxt;

  assign cfg = unpack_cfg(config_reg);
  assign cfg_unused =
    ^{config_reg[127:72], config_reg[47:34]};
  assign off_in = ADDR_WIDTH'(cfg.offset);

  assign accept = (state_q == ST_IDLE) && start_i;
  assign remain = issued_q < depth_q;
  assign issue  = (state_q == ST_RUN) && remain &&
                  !abort_i && !afull_i;
  assign stall  = (state_q == ST_RUN) && remain &&
                  afull_i && !abort_i;

  always_comb begin
    start_addr = '0;
    unique case (1'b1)
      cfg.mode == MODE_OFFSET,
      cfg.mode == MODE_CIRC: start_addr = off_in;
      cfg.mode == MODE_CONT: start_addr = cont_q;
      default:               start_addr = '0;
    endcase
  end

  // stride < wrap, so one subtraction folds pos back
  assign pos_sum = pos_q + PW'(stride_q);
  assign pos_nxt = (pos_sum >= wrap_q) ?
                   pos_sum - wrap_q : pos_sum;
  assign addr_step = (mode_q == MODE_CIRC) ?
    offset_q + ADDR_WIDTH'(pos_nxt) :
    addr_q + ADDR_WIDTH'(stride_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (start_i) state_d = ST_RUN;
      ST_RUN:
        if (abort_i || !remain) state_d = ST_DRAIN;
      ST_DRAIN:
        if (!inflight)
          state_d = (aborted_q || abort_i) ?
                    ST_IDLE : ST_DONE;
      ST_DONE:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_LINEAR;
      depth_q   <= '0;
      issued_q  <= '0;
      offset_q  <= '0;
      stride_q  <= 8'd1;
      wrap_q    <= '0;
      addr_q    <= '0;
      pos_q     <= '0;
      cont_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q    <= cfg.mode;
        depth_q   <= CNT_WIDTH'(cfg.depth);
        offset_q  <= off_in;
        stride_q  <= (cfg.stride == '0) ?
                     8'd1 : cfg.stride;
        wrap_q    <= (cfg.wrap == '0) ?
                     (PW'(1) << ADDR_WIDTH) :
                     PW'(cfg.wrap);
        issued_q  <= '0;
        addr_q    <= start_addr;
        pos_q     <= '0;
        aborted_q <= 1'b0;
      end else if (issue) begin
        issued_q <= issued_q + CNT_WIDTH'(1);
        addr_q   <= addr_step;
        pos_q    <= pos_nxt;
      end
      if (abort_i && (state_q == ST_RUN ||
                      state_q == ST_DRAIN))
        aborted_q <= 1'b1;
      // continue pointer only on clean completion
      if (state_q == ST_DRAIN && state_d == ST_DONE)
        cont_q <= addr_q;
    end
  end

  source_delay_line #(
    .DEPTH(READ_LAT)
  ) u_dly (
    .clk     (clk),
    .rst     (rst),
    .valid   (re_mem_o),
    .delayed (we_fifo_o),
    .pending (inflight)
  );

  assign re_mem_o   = issue;
  assign addr_mem_o = addr_q;
  assign data_o     = data_in;
  assign status_reg = {4'b0000, aborted_q, stall,
                       state_q != ST_IDLE,
                       state_q == ST_DONE};

endmodule

// File: tb/tb_source_stream.sv
// tb_source_stream: directed stimulus with a queue
// scoreboard for two source_stream instances.
module tb_source_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start1, abort1, afull1;
  logic         start3, abort3, afull3;
  logic [127:0] cfg1, cfg3;
  logic [31:0]  din1, dout1, din3, dout3;
  logic         re1, we1, re3, we3;
  logic [9:0]   addr1, addr3;
  logic [7:0]   st1, st3;

  source_stream #(.READ_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .start_i(start1), .abort_i(abort1),
    .afull_i(afull1), .config_reg(cfg1),
    .data_in(din1), .re_mem_o(re1),
    .addr_mem_o(addr1), .we_fifo_o(we1),
    .data_o(dout1), .status_reg(st1)
  );

  source_stream #(.READ_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .start_i(start3), .abort_i(abort3),
    .afull_i(afull3), .config_reg(cfg3),
    .data_in(din3), .re_mem_o(re3),
    .addr_mem_o(addr3), .we_fifo_o(we3),
    .data_o(dout3), .status_reg(st3)
  );

  function automatic logic [31:0] pat(
    input logic [9:0] a
  );
    return {16'hBEEF, 6'd0, a};
  endfunction

  // memory models with matching read latency
  logic [31:0] p3 [3];
  always @(posedge clk) begin
    din1  <= pat(addr1);
    p3[0] <= pat(addr3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign din3 = p3[2];

  int pass_n = 0;
  int total_n = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic miss(input string name);
    total_n++;
    $display("FAIL %s: output with empty queue", name);
  endtask

  logic [9:0]  ea1[$], ea3[$];
  logic [31:0] ed1[$], ed3[$];
  int rc1 = 0, wc1 = 0, dc1 = 0, sc1 = 0;
  int rc3 = 0, wc3 = 0, dc3 = 0;

  always @(negedge clk) begin
    if (re1 === 1'b1) begin
      rc1++;
      if (ea1.size() == 0) miss("addr1");
      else begin
        chk("addr1", 32'(addr1), 32'(ea1[0]));
        ed1.push_back(pat(ea1[0]));
        ea1.delete(0);
      end
    end
    if (we1 === 1'b1) begin
      wc1++;
      if (ed1.size() == 0) miss("data1");
      else begin
        chk("data1", dout1, ed1[0]);
        ed1.delete(0);
      end
    end
    if (st1[0] === 1'b1) dc1++;
    if (st1[2] === 1'b1) sc1++;
    if (re3 === 1'b1) begin
      rc3++;
      if (ea3.size() == 0) miss("addr3");
      else begin
        chk("addr3", 32'(addr3), 32'(ea3[0]));
        ed3.push_back(pat(ea3[0]));
        ea3.delete(0);
      end
    end
    if (we3 === 1'b1) begin
      wc3++;
      if (ed3.size() == 0) miss("data3");
      else begin
        chk("data3", dout3, ed3[0]);
        ed3.delete(0);
      end
    end
    if (st3[0] === 1'b1) dc3++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk(
    input logic [1:0]  mode,
    input logic [15:0] depth,
    input logic [15:0] offset,
    input logic [15:0] wrap,
    input logic [7:0]  stride
  );
    logic [127:0] c;
    c = '1;
    c[15:0]  = depth;
    c[31:16] = offset;
    c[33:32] = mode;
    c[63:48] = wrap;
    c[71:64] = stride;
    return c;
  endfunction

  task automatic go1(input logic [127:0] c);
    cfg1 = c; start1 = 1'b1;
    tick();
    start1 = 1'b0; cfg1 = '1;
  endtask

  task automatic go3(input logic [127:0] c);
    cfg3 = c; start3 = 1'b1;
    tick();
    start3 = 1'b0; cfg3 = '1;
  endtask

  task automatic idle1();
    for (int i = 0; i < 200; i++) begin
      if (st1[1] == 1'b0) break;
      tick();
    end
    chk("idle1_wait", 32'(st1[1]), 32'd0);
  endtask

  task automatic idle3();
    for (int i = 0; i < 200; i++) begin
      if (st3[1] == 1'b0) break;
      tick();
    end
    chk("idle3_wait", 32'(st3[1]), 32'd0);
  endtask

  task automatic wait_rc1(input int n);
    for (int i = 0; i < 100; i++) begin
      if (rc1 >= n) break;
      tick();
    end
    chk("rc1_wait", 32'(rc1 >= n), 32'd1);
  endtask

  task automatic wait_rc3(input int n);
    for (int i = 0; i < 100; i++) begin
      if (rc3 >= n) break;
      tick();
    end
    chk("rc3_wait", 32'(rc3 >= n), 32'd1);
  endtask

  int bw, bd, bs;

  initial begin
    rst = 1'b1;
    start1 = 0; abort1 = 0; afull1 = 0;
    start3 = 0; abort3 = 0; afull3 = 0;
    cfg1 = '0; cfg3 = '0;
    repeat (3) tick();
    chk("rst_st1", 32'(st1), 32'd0);
    chk("rst_st3", 32'(st3), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_re1", 32'(re1), 32'd0);
    chk("rst_we3", 32'(we3), 32'd0);

    // depth 0: no reads, one done
    bd = dc1;
    go1(mk(2'b00, 16'd0, 16'd0, 16'd0, 8'd1));
    idle1();
    chk("d0_done", 32'(dc1 - bd), 32'd1);
    chk("d0_reads", 32'(rc1), 32'd0);

    // linear, depth 8
    for (int i = 0; i < 8; i++) ea1.push_back(10'(i));
    bw = wc1; bd = dc1;
    go1(mk(2'b00, 16'd8, 16'd0, 16'd0, 8'd1));
    idle1();
    chk("lin_writes", 32'(wc1 - bw), 32'd8);
    chk("lin_done", 32'(dc1 - bd), 32'd1);
    chk("lin_q", 32'(ea1.size() + ed1.size()), 32'd0);

    // offset, stride 3, afull window
    ea1.push_back(10'd100); ea1.push_back(10'd103);
    ea1.push_back(10'd106); ea1.push_back(10'd109);
    bw = wc1; bs = sc1;
    go1(mk(2'b01, 16'd4, 16'd100, 16'd0, 8'd3));
    wait_rc1(rc1 + 2);
    afull1 = 1'b1;
    repeat (5) tick();
    afull1 = 1'b0;
    idle1();
    chk("off_stall", 32'(sc1 - bs), 32'd5);
    chk("off_writes", 32'(wc1 - bw), 32'd4);
    chk("off_q", 32'(ea1.size() + ed1.size()), 32'd0);

    // circular wrap
    ea1.push_back(10'd16); ea1.push_back(10'd18);
    ea1.push_back(10'd20); ea1.push_back(10'd17);
    ea1.push_back(10'd19); ea1.push_back(10'd16);
    go1(mk(2'b11, 16'd6, 16'd16, 16'd5, 8'd2));
    idle1();
    chk("circ_q", 32'(ea1.size() + ed1.size()), 32'd0);

    // linear 4 then continue 3
    for (int i = 0; i < 7; i++) ea1.push_back(10'(i));
    go1(mk(2'b00, 16'd4, 16'd0, 16'd0, 8'd1));
    idle1();
    go1(mk(2'b10, 16'd3, 16'd500, 16'd0, 8'd0));
    idle1();
    chk("cont_q", 32'(ea1.size() + ed1.size()), 32'd0);

    // latency 3: clean run sets continue ptr 3
    for (int i = 0; i < 3; i++) ea3.push_back(10'(i));
    bd = dc3;
    go3(mk(2'b00, 16'd3, 16'd0, 16'd0, 8'd1));
    idle3();
    chk("l3_done", 32'(dc3 - bd), 32'd1);

    // abort after 4th read
    for (int i = 3; i < 7; i++) ea3.push_back(10'(i));
    bw = wc3; bd = dc3;
    go3(mk(2'b10, 16'd10, 16'd0, 16'd0, 8'd1));
    wait_rc3(rc3 + 4);
    abort3 = 1'b1;
    tick();
    abort3 = 1'b0;
    idle3();
    chk("abt_writes", 32'(wc3 - bw), 32'd4);
    chk("abt_done", 32'(dc3 - bd), 32'd0);
    chk("abt_flag", 32'(st3[3]), 32'd1);
    chk("abt_q", 32'(ea3.size() + ed3.size()), 32'd0);

    // reset with two reads in flight
    ea3.push_back(10'd3); ea3.push_back(10'd4);
    go3(mk(2'b10, 16'd10, 16'd0, 16'd0, 8'd1));
    chk("abt_clear", 32'(st3[3]), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bw = wc3;
    chk("rst2_st3", 32'(st3), 32'd0);
    chk("rst2_re3", 32'(re3), 32'd0);
    chk("rst2_we3", 32'(we3), 32'd0);
    repeat (8) tick();
    chk("rst2_nowr", 32'(wc3 - bw), 32'd0);
    chk("rst2_lost", 32'(ed3.size()), 32'd2);
    ed3.delete();
    chk("rst2_ea", 32'(ea3.size()), 32'd0);

    // continue pointer cleared by reset
    ea3.push_back(10'd0); ea3.push_back(10'd1);
    bd = dc3;
    go3(mk(2'b10, 16'd2, 16'd0, 16'd0, 8'd1));
    idle3();
    chk("rst2_done", 32'(dc3 - bd), 32'd1);
    chk("rst2_q", 32'(ea3.size() + ed3.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
